// File: rtl/pipelined_carry_select_subtractor.sv
// Two-stage carry-select subtractor: D = A - B - bin with borrow-out behind a valid/ready handshake.
// Optional signed-overflow output is compiled in when OVERFLOW_FLAG_EN is defined.
module pipelined_carry_select_subtractor #(
  parameter int N   = 16,
  parameter int SEG = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_bin,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [N-1:0] o_d,
  output logic         o_bout
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic         o_ovf
`endif
);

  localparam int NSEG = N / SEG;

  if ((N % SEG) != 0) begin : g_bad_seg
    $error("pipelined_carry_select_subtractor: N must be a multiple of SEG");
  end

  logic w_s1En;
  logic w_s2En;

  logic r_v1;
  logic r_v2;
  logic r_binR;

  logic [NSEG-1:0][SEG-1:0] w_diff0;
  logic [NSEG-1:0][SEG-1:0] w_diff1;
  logic [NSEG-1:0]          w_bor0;
  logic [NSEG-1:0]          w_bor1;

  logic [NSEG-1:0][SEG-1:0] r_diff0;
  logic [NSEG-1:0][SEG-1:0] r_diff1;
  logic [NSEG-1:0]          r_bor0;
  logic [NSEG-1:0]          r_bor1;

  logic [N-1:0] w_dNext;
  logic         w_boutNext;

  logic [N-1:0] r_d;
  logic         r_bout;

  assign w_s2En      = !r_v2 || i_out_ready;
  assign w_s1En      = !r_v1 || w_s2En;
  assign o_in_ready  = w_s1En;
  assign o_out_valid = r_v2;
  assign o_d         = r_d;
  assign o_bout      = r_bout;

  // Each segment subtracts in SEG+1 bits so the MSB of the result is that segment's borrow.
  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    logic [SEG:0] w_sub0;
    logic [SEG:0] w_sub1;

    assign w_sub0     = {1'b0, i_a[k*SEG +: SEG]} - {1'b0, i_b[k*SEG +: SEG]};
    assign w_sub1     = w_sub0 - {{SEG{1'b0}}, 1'b1};
    assign w_diff0[k] = w_sub0[SEG-1:0];
    assign w_diff1[k] = w_sub1[SEG-1:0];
    assign w_bor0[k]  = w_sub0[SEG];
    assign w_bor1[k]  = w_sub1[SEG];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1    <= 1'b0;
      r_binR  <= 1'b0;
      r_diff0 <= '0;
      r_diff1 <= '0;
      r_bor0  <= '0;
      r_bor1  <= '0;
    end else if (w_s1En) begin
      r_v1 <= i_in_valid;
      if (i_in_valid) begin
        r_binR  <= i_bin;
        r_diff0 <= w_diff0;
        r_diff1 <= w_diff1;
        r_bor0  <= w_bor0;
        r_bor1  <= w_bor1;
      end
    end
  end

  // Borrow-select chain: the registered borrow-in picks each segment's precomputed candidate.
  always_comb begin : p_select
    logic sel;
    sel     = r_binR;
    w_dNext = '0;
    for (int k = 0; k < NSEG; k++) begin
      w_dNext[k*SEG +: SEG] = sel ? r_diff1[k] : r_diff0[k];
      sel                   = sel ? r_bor1[k] : r_bor0[k];
    end
    w_boutNext = sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2   <= 1'b0;
      r_d    <= '0;
      r_bout <= 1'b0;
    end else if (w_s2En) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_d    <= w_dNext;
        r_bout <= w_boutNext;
      end
    end
  end

`ifdef OVERFLOW_FLAG_EN
  logic r_signA;
  logic r_signB;
  logic r_ovf;

  assign o_ovf = r_ovf;

  // Signed overflow only arises when operand signs differ and the result sign departs from A.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_signA <= 1'b0;
      r_signB <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_s1En && i_in_valid) begin
        r_signA <= i_a[N-1];
        r_signB <= i_b[N-1];
      end
      if (w_s2En && r_v1) begin
        r_ovf <= (r_signA != r_signB) && (w_dNext[N-1] != r_signA);
      end
    end
  end
`endif

endmodule
